// File: rtl/ndp_tile_sequencer.sv
// NDP_unit tile driver: command + K operand beats in, ROWS result rows out over valid/ready (stalls hold the row).
// Optional WAIT watchdog enabled by defining NDP_SEQ_TIMEOUT_EN.
module ndp_tile_sequencer #(
  parameter int WIDTH          = 16,
  parameter int ARR_HEIGHT     = 4,
  parameter int ARR_WIDTH      = 4,
  parameter int SYS_HEIGHT     = 1,
  parameter int SYS_WIDTH      = 64,
  parameter int KW             = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int ROWS = SYS_HEIGHT * ARR_HEIGHT,
  localparam int COLS = SYS_WIDTH * ARR_WIDTH,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [KW-1:0]              cmd_k,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [ROWS*WIDTH-1:0]      op_a,
  input  logic [COLS*WIDTH-1:0]      op_b,
  output logic                       nd_reset,
  output logic [ROWS*WIDTH-1:0]      nd_in_a,
  output logic [COLS*WIDTH-1:0]      nd_in_b,
  output logic                       nd_in_done_flag,
  input  logic                       nd_calc_done_flag,
  input  logic [ROWS*COLS*WIDTH-1:0] nd_out_c,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [COLS*WIDTH-1:0]      res_data,
  output logic [RW-1:0]              res_row,
  output logic                       res_last,
  output logic                       busy,
  output logic                       err
);
  localparam int AW = ROWS * WIDTH;
  localparam int BW = COLS * WIDTH;
  localparam int CW = ROWS * BW;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
`ifdef NDP_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_FLUSH, S_WAIT, S_DRAIN} state_t;

  state_t        r_state, w_next;
  logic [KW-1:0] r_k, r_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_nd_reset, r_done, r_err;
  logic [AW-1:0] r_in_a;
  logic [BW-1:0] r_in_b;
  logic [CW-1:0] r_res;
  logic [RW-1:0] r_row;
  logic          w_op_hs, w_last_beat, w_tmo, w_err, w_nd_reset;

  assign w_op_hs     = op_valid && (r_state == S_FEED);
  assign w_last_beat = (r_cnt == r_k - KW'(1));
  assign w_tmo       = TMO_EN && (r_tmo == TMO_LAST);

  always_comb begin
    w_next     = r_state;
    w_err      = 1'b0;
    w_nd_reset = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_k != '0) begin
            w_next     = S_CLR;
            w_nd_reset = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_CLR:   w_next = S_FEED;
      S_FEED:  if (op_valid && w_last_beat) w_next = S_FLUSH;
      S_FLUSH: w_next = S_WAIT;
      S_WAIT: begin
        // completion wins over a watchdog expiry in the same cycle
        if (nd_calc_done_flag) begin
          w_next = S_DRAIN;
        end else if (w_tmo) begin
          w_next     = S_IDLE;
          w_err      = 1'b1;
          w_nd_reset = 1'b1;
        end
      end
      S_DRAIN: if (res_ready && (r_row == LAST_ROW)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_nd_reset <= 1'b1;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_in_a     <= '0;
      r_in_b     <= '0;
      r_k        <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_row      <= '0;
    end else begin
      r_state    <= w_next;
      r_nd_reset <= w_nd_reset;
      r_err      <= w_err;
      if ((r_state == S_IDLE) && (w_next == S_CLR)) begin
        r_k    <= cmd_k;
        r_cnt  <= '0;
        r_done <= 1'b0;
        r_in_a <= '0;
        r_in_b <= '0;
      end
      // idle FEED cycles present zeros so the array accumulates nothing
      if (r_state == S_FEED) begin
        r_in_a <= w_op_hs ? op_a : '0;
        r_in_b <= w_op_hs ? op_b : '0;
        if (w_op_hs) r_cnt <= r_cnt + KW'(1);
      end
      if (r_state == S_FLUSH) begin
        r_done <= 1'b1;
        r_tmo  <= '0;
      end
      if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + TW'(1);
        if (nd_calc_done_flag) r_row <= '0;
      end
      if ((r_state == S_DRAIN) && res_ready) begin
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_WAIT) && nd_calc_done_flag) r_res <= nd_out_c;
  end

  assign cmd_ready       = (r_state == S_IDLE);
  assign op_ready        = (r_state == S_FEED);
  assign busy            = (r_state != S_IDLE);
  assign res_valid       = (r_state == S_DRAIN);
  assign nd_reset        = r_nd_reset;
  assign nd_in_a         = r_in_a;
  assign nd_in_b         = r_in_b;
  assign nd_in_done_flag = r_done;
  assign err             = r_err;
  assign res_row         = r_row;
  assign res_last        = (r_state == S_DRAIN) && (r_row == LAST_ROW);
  assign res_data        = r_res[int'(r_row) * BW +: BW];

endmodule

// File: tb/tb_ndp_tile_sequencer.sv
// Directed + randomized bench for ndp_tile_sequencer with an inline NDP_unit stub and expected-value model.
module tb_ndp_tile_sequencer;
  localparam int WIDTH = 16, ARR_HEIGHT = 4, ARR_WIDTH = 4, SYS_HEIGHT = 1, SYS_WIDTH = 64;
  localparam int KW = 8, TMO = 16;
  localparam int ROWS = SYS_HEIGHT * ARR_HEIGHT, COLS = SYS_WIDTH * ARR_WIDTH, RW = 2;
  localparam int AW = ROWS * WIDTH, BW = COLS * WIDTH, CW = ROWS * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [KW-1:0] cmd_k;
  logic          op_valid, op_ready;
  logic [AW-1:0] op_a, nd_in_a;
  logic [BW-1:0] op_b, nd_in_b, res_data;
  logic          nd_reset, nd_in_done_flag, nd_calc_done_flag;
  logic [CW-1:0] nd_out_c;
  logic          res_valid, res_ready, res_last, busy, err;
  logic [RW-1:0] res_row;

  int n_assert = 0;
  int n_fail   = 0;
  logic [BW-1:0] exp_rows [ROWS];

  always #5 clk = ~clk;

  ndp_tile_sequencer #(
    .WIDTH(WIDTH), .ARR_HEIGHT(ARR_HEIGHT), .ARR_WIDTH(ARR_WIDTH),
    .SYS_HEIGHT(SYS_HEIGHT), .SYS_WIDTH(SYS_WIDTH), .KW(KW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .nd_reset(nd_reset), .nd_in_a(nd_in_a), .nd_in_b(nd_in_b),
    .nd_in_done_flag(nd_in_done_flag), .nd_calc_done_flag(nd_calc_done_flag),
    .nd_out_c(nd_out_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_last(res_last), .busy(busy), .err(err)
  );

  task automatic check(input string tag, input bit ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [AW-1:0] rand_a();
    logic [AW-1:0] v;
    for (int i = 0; i < AW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_b();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Issue a command and K beats; returns positioned on the first WAIT cycle.
  task automatic start_tile(input int k, input int gap_at, input int gap_len,
                            input bit rnd_idle, input bit spurious);
    int acc, idle, guard;
    bit v;
    logic [AW-1:0] ea;
    logic [BW-1:0] eb;
    check("idle_cmd_ready", cmd_ready === 1'b1);
    cmd_valid = 1'b1;
    cmd_k     = KW'(k);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("clr_nd_reset", nd_reset === 1'b1);
    check("clr_done", nd_in_done_flag === 1'b0);
    check("clr_bus_a", nd_in_a === AW'(0));
    check("clr_op_ready", op_ready === 1'b0);
    check("clr_busy", busy === 1'b1);
    ea = '0; eb = '0; acc = 0; idle = 0; guard = 0;
    while (acc < k && guard < 500) begin
      @(negedge clk);
      guard++;
      check("feed_op_ready", op_ready === 1'b1);
      check("feed_nd_reset", nd_reset === 1'b0);
      check("feed_done", nd_in_done_flag === 1'b0);
      check("feed_cmd_ready", cmd_ready === 1'b0);
      check("feed_bus_a", nd_in_a === ea);
      check("feed_bus_b", nd_in_b === eb);
      v = 1'b1;
      if (gap_at >= 0 && acc == gap_at && idle < gap_len) begin
        v = 1'b0;
        idle++;
      end else if (rnd_idle && $urandom_range(0, 1) == 0) begin
        v = 1'b0;
      end
      op_valid = v;
      op_a     = rand_a();
      op_b     = rand_b();
      nd_calc_done_flag = spurious;
      if (v && op_ready === 1'b1) begin
        ea = op_a; eb = op_b; acc++;
      end else begin
        ea = '0; eb = '0;
      end
    end
    check("feed_beats_accepted", acc === k);
    @(negedge clk);
    nd_calc_done_flag = 1'b0;
    op_valid = 1'b1;
    op_a = rand_a();
    op_b = rand_b();
    check("flush_bus_a", nd_in_a === ea);
    check("flush_bus_b", nd_in_b === eb);
    check("flush_done", nd_in_done_flag === 1'b0);
    check("flush_op_ready", op_ready === 1'b0);
    @(negedge clk);
    op_valid = 1'b0;
    check("wait_done", nd_in_done_flag === 1'b1);
    check("wait_bus_a", nd_in_a === ea);
    check("wait_bus_b", nd_in_b === eb);
    check("wait_res_valid", res_valid === 1'b0);
  endtask

  // Stub completes after lat WAIT cycles; then drain all rows, optionally stalling one.
  task automatic finish_tile(input int lat, input bit pattern, input int stall_row, input int stall_len);
    logic [CW-1:0] oc;
    for (int r = 0; r < ROWS; r++) begin
      if (pattern) begin
        for (int e = 0; e < COLS; e++) exp_rows[r][e*WIDTH +: WIDTH] = WIDTH'(r + 1);
      end else begin
        exp_rows[r] = rand_b();
      end
      oc[r*BW +: BW] = exp_rows[r];
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("wait_hold_res_valid", res_valid === 1'b0);
      check("wait_hold_busy", busy === 1'b1);
    end
    nd_calc_done_flag = 1'b1;
    nd_out_c = oc;
    @(negedge clk);
    nd_calc_done_flag = 1'b0;
    nd_out_c  = ~oc;
    res_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      check("drain_valid", res_valid === 1'b1);
      check("drain_row", res_row === RW'(r));
      check("drain_last", res_last === 1'(r == ROWS - 1));
      check("drain_data", res_data === exp_rows[r]);
      if (r == stall_row) begin
        res_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check("stall_valid", res_valid === 1'b1);
          check("stall_row", res_row === RW'(r));
          check("stall_data", res_data === exp_rows[r]);
        end
        res_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("end_busy", busy === 1'b0);
    check("end_res_valid", res_valid === 1'b0);
    check("end_done_held", nd_in_done_flag === 1'b1);
    check("end_cmd_ready", cmd_ready === 1'b1);
    check("end_err", err === 1'b0);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_k = '0; op_valid = 1'b0; op_a = '0; op_b = '0;
    nd_calc_done_flag = 1'b0; nd_out_c = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_nd_reset", nd_reset === 1'b1);
    check("rst_in_a", nd_in_a === AW'(0));
    check("rst_in_b", nd_in_b === BW'(0));
    check("rst_done", nd_in_done_flag === 1'b0);
    check("rst_res_valid", res_valid === 1'b0);
    check("rst_res_row", res_row === RW'(0));
    check("rst_res_last", res_last === 1'b0);
    check("rst_err", err === 1'b0);
    check("rst_busy", busy === 1'b0);
    check("rst_op_ready", op_ready === 1'b0);
    check("rst_cmd_ready", cmd_ready === 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rel_nd_reset", nd_reset === 1'b0);

    start_tile(5, -1, 0, 1'b0, 1'b0);
    finish_tile(3, 1'b1, -1, 0);

    start_tile(3, 1, 2, 1'b0, 1'b1);
    finish_tile(2, 1'b0, 1, 4);

    check("k0_err_before", err === 1'b0);
    cmd_valid = 1'b1; cmd_k = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("k0_err_pulse", err === 1'b1);
    check("k0_cmd_ready", cmd_ready === 1'b1);
    check("k0_busy", busy === 1'b0);
    check("k0_nd_reset", nd_reset === 1'b0);
    @(negedge clk);
    check("k0_err_clear", err === 1'b0);
    check("k0_nd_reset_2", nd_reset === 1'b0);

    cmd_valid = 1'b1; cmd_k = KW'(5);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      op_valid = 1'b1; op_a = rand_a(); op_b = rand_b();
    end
    @(negedge clk);
    op_valid = 1'b0;
    check("mid_op_ready", op_ready === 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy === 1'b0);
    check("mid_rst_done", nd_in_done_flag === 1'b0);
    check("mid_rst_res_valid", res_valid === 1'b0);
    check("mid_rst_nd_reset", nd_reset === 1'b1);
    check("mid_rst_in_a", nd_in_a === AW'(0));
    check("mid_rst_op_ready", op_ready === 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rel_nd_reset", nd_reset === 1'b0);
    start_tile(2, -1, 0, 1'b0, 1'b0);
    finish_tile(1, 1'b0, -1, 0);

    for (int t = 0; t < 3; t++) begin
      start_tile($urandom_range(1, 8), -1, 0, 1'b1, 1'b0);
      finish_tile($urandom_range(0, 4), 1'b0, $urandom_range(0, ROWS - 1), $urandom_range(1, 3));
    end

    start_tile(2, -1, 0, 1'b0, 1'b0);
`ifdef NDP_SEQ_TIMEOUT_EN
    for (int i = 1; i <= TMO; i++) begin
      check("tmo_wait_err", err === 1'b0);
      check("tmo_wait_busy", busy === 1'b1);
      if (i < TMO) @(negedge clk);
    end
    @(negedge clk);
    check("tmo_err", err === 1'b1);
    check("tmo_busy", busy === 1'b0);
    check("tmo_nd_reset", nd_reset === 1'b1);
    check("tmo_res_valid", res_valid === 1'b0);
    @(negedge clk);
    check("tmo_err_clear", err === 1'b0);
    check("tmo_nd_reset_clear", nd_reset === 1'b0);
`else
    repeat (100) @(negedge clk);
    check("hang_busy", busy === 1'b1);
    check("hang_res_valid", res_valid === 1'b0);
    check("hang_err", err === 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif
    check("final_cmd_ready", cmd_ready === 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not complete, %0d assertions evaluated", n_assert);
    $fatal(1, "bench time limit");
  end

endmodule
